// File: rtl/x_fifo_pkg.sv
// Shared helpers and types for the multi-channel FIFO: safe clog2,
// level threshold compare, and the per-channel status record.
package x_fifo_pkg;

  function automatic int safe_clog2(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // ge=1: lvl >= thr (almost-full); ge=0: lvl <= thr (almost-empty)
  function automatic logic lvl_cmp(input int lvl, input int thr, input logic ge);
    return ge ? (lvl >= thr) : (lvl <= thr);
  endfunction

  typedef struct packed {
    logic full_n;
    logic empty_n;
    logic afull;
    logic aempty;
    logic ovf;
    logic udf;
  } ch_flags_t;

endpackage

// File: rtl/x_mc_fifo_chctl.sv
// Per-channel control: read/write pointers, fill level, status flags and
// sticky overflow/underflow. Flags decode only from registered pointers.
module x_mc_fifo_chctl
  import x_fifo_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1,
  parameter int AW     = safe_clog2(DEPTH),
  parameter int LW     = AW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_req,
  input  logic          rd_req,
  input  logic          clr_err,
  output logic          wr_ok,
  output logic          rd_ok,
  output logic [AW-1:0] wlo,
  output logic [AW-1:0] rlo,
  output logic [LW-1:0] level,
  output ch_flags_t     st
);

  logic [LW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          full, empty;

  assign level = wptr_q - rptr_q;
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign wlo   = wptr_q[AW-1:0];
  assign rlo   = rptr_q[AW-1:0];

  // Acceptance uses last-edge state, so a full channel rejects a write even
  // when a read frees a slot in the same cycle (and vice versa for empty).
  assign wr_ok = wr_req & ~full;
  assign rd_ok = rd_req & ~empty;

  always_comb begin
    wptr_d = wptr_q + LW'(wr_ok);
    rptr_d = rptr_q + LW'(rd_ok);
    ovf_d  = clr_err ? 1'b0 : (ovf_q | (wr_req & full));
    udf_d  = clr_err ? 1'b0 : (udf_q | (rd_req & empty));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  always_comb begin
    st         = '0;
    st.full_n  = ~full;
    st.empty_n = ~empty;
    st.afull   = lvl_cmp(int'(level), AF_LVL, 1'b1);
    st.aempty  = lvl_cmp(int'(level), AE_LVL, 1'b0);
    st.ovf     = ovf_q;
    st.udf     = udf_q;
  end

endmodule

// File: rtl/x_mc_sync_fifo.sv
// Multi-channel single-clock FIFO: NCH logical queues sharing one storage
// array addressed {ch,ptr}, with a registered read-data stage.
module x_mc_sync_fifo
  import x_fifo_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DEPTH  = 4,
  parameter int DW     = 8,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1,
  parameter int CW     = safe_clog2(NCH),
  parameter int AW     = safe_clog2(DEPTH),
  parameter int LW     = AW + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [CW-1:0]     wch,
  input  logic [DW-1:0]     din,
  input  logic              re,
  input  logic [CW-1:0]     rch,
  output logic [DW-1:0]     dout,
  output logic              rvalid,
  output logic [CW-1:0]     rvch,
  output logic [NCH-1:0]    full_n,
  output logic [NCH-1:0]    empty_n,
  output logic [NCH-1:0]    afull,
  output logic [NCH-1:0]    aempty,
  output logic [NCH*LW-1:0] level,
  output logic [NCH-1:0]    ovf,
  output logic [NCH-1:0]    udf,
  input  logic              clr_err
);

  logic [NCH-1:0]         wr_ok, rd_ok;
  logic [NCH-1:0][AW-1:0] wlo, rlo;
  ch_flags_t              st [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    x_mc_fifo_chctl #(
      .DEPTH (DEPTH), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL), .AW(AW), .LW(LW)
    ) u_chctl (
      .clk    (clk),
      .rstn   (rstn),
      .wr_req (we & (wch == CW'(c))),
      .rd_req (re & (rch == CW'(c))),
      .clr_err(clr_err),
      .wr_ok  (wr_ok[c]),
      .rd_ok  (rd_ok[c]),
      .wlo    (wlo[c]),
      .rlo    (rlo[c]),
      .level  (level[c*LW +: LW]),
      .st     (st[c])
    );
    assign full_n[c]  = st[c].full_n;
    assign empty_n[c] = st[c].empty_n;
    assign afull[c]   = st[c].afull;
    assign aempty[c]  = st[c].aempty;
    assign ovf[c]     = st[c].ovf;
    assign udf[c]     = st[c].udf;
  end

  // Shared storage; no reset needed since empty channels are never read.
  logic [DW-1:0]    mem_q [NCH*DEPTH];
  logic [CW+AW-1:0] waddr, raddr;

  assign waddr = {wch, wlo[wch]};
  assign raddr = {rch, rlo[rch]};

  always_ff @(posedge clk) begin
    if (|wr_ok) mem_q[waddr] <= din;
  end

  logic [DW-1:0] dout_q, dout_d;
  logic [CW-1:0] rvch_q, rvch_d;
  logic          rvalid_q, rvalid_d;

  always_comb begin
    dout_d   = dout_q;
    rvch_d   = rvch_q;
    rvalid_d = |rd_ok;
    if (|rd_ok) begin
      dout_d = mem_q[raddr];
      rvch_d = rch;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q   <= '0;
      rvch_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      rvch_q   <= rvch_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign dout   = dout_q;
  assign rvch   = rvch_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_x_mc_sync_fifo.sv
// Randomized + directed bench for x_mc_sync_fifo against a queue-per-channel
// reference model.
module tb_x_mc_sync_fifo;
  localparam int NCH = 4, DEPTH = 4, DW = 8, CW = 2, LW = 3;

  logic              clk = 0, rstn = 0;
  logic              we = 0, re = 0, clr_err = 0;
  logic [CW-1:0]     wch = 0, rch = 0;
  logic [DW-1:0]     din = 0;
  logic [DW-1:0]     dout;
  logic              rvalid;
  logic [CW-1:0]     rvch;
  logic [NCH-1:0]    full_n, empty_n, afull, aempty, ovf, udf;
  logic [NCH*LW-1:0] level;

  x_mc_sync_fifo #(.NCH(NCH), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .we(we), .wch(wch), .din(din), .re(re), .rch(rch),
    .dout(dout), .rvalid(rvalid), .rvch(rvch), .full_n(full_n), .empty_n(empty_n),
    .afull(afull), .aempty(aempty), .level(level), .ovf(ovf), .udf(udf),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  logic [DW-1:0]  q [NCH][$];
  logic [NCH-1:0] m_ovf, m_udf;
  logic           m_rvalid;
  logic [CW-1:0]  m_rvch;
  logic [DW-1:0]  m_dout;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) q[c].delete();
    m_ovf = '0; m_udf = '0; m_rvalid = 0; m_rvch = '0; m_dout = '0;
  endtask

  task automatic check_all(input string tag);
    logic [NCH-1:0]    e_full_n, e_empty_n, e_afull, e_aempty;
    logic [NCH*LW-1:0] e_level;
    for (int c = 0; c < NCH; c++) begin
      int n = q[c].size();
      e_full_n[c]        = (n != DEPTH);
      e_empty_n[c]       = (n != 0);
      e_afull[c]         = (n >= DEPTH - 1);
      e_aempty[c]        = (n <= 1);
      e_level[c*LW +: LW] = LW'(n);
    end
    chk({tag, ".level"},   level,   e_level);
    chk({tag, ".full_n"},  full_n,  e_full_n);
    chk({tag, ".empty_n"}, empty_n, e_empty_n);
    chk({tag, ".afull"},   afull,   e_afull);
    chk({tag, ".aempty"},  aempty,  e_aempty);
    chk({tag, ".ovf"},     ovf,     m_ovf);
    chk({tag, ".udf"},     udf,     m_udf);
    chk({tag, ".rvalid"},  rvalid,  m_rvalid);
    chk({tag, ".dout"},    dout,    m_dout);
    chk({tag, ".rvch"},    rvch,    m_rvch);
  endtask

  // One clock: drive at negedge, update model at posedge using pre-edge sizes,
  // check 1ns after the edge.
  task automatic op(input string tag, input bit w, input int wc, input int d,
                    input bit r, input int rc, input bit c);
    int ws, rs;
    @(negedge clk);
    we = w; wch = CW'(wc); din = DW'(d); re = r; rch = CW'(rc); clr_err = c;
    @(posedge clk);
    ws = q[wc].size();
    rs = q[rc].size();
    m_rvalid = 0;
    if (r) begin
      if (rs > 0) begin
        m_dout = q[rc].pop_front(); m_rvch = CW'(rc); m_rvalid = 1;
      end else m_udf[rc] = 1;
    end
    if (w) begin
      if (ws < DEPTH) q[wc].push_back(DW'(d));
      else m_ovf[wc] = 1;
    end
    if (c) begin m_ovf = '0; m_udf = '0; end
    #1;
    check_all(tag);
    we = 0; re = 0; clr_err = 0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("in_reset");
    @(negedge clk); rstn = 1;
    op("idle", 0, 0, 0, 0, 0, 0);

    // basic ordering on ch1
    op("w_a1", 1, 1, 'hA1, 0, 0, 0);
    op("w_a2", 1, 1, 'hA2, 0, 0, 0);
    op("r1_a", 0, 0, 0, 1, 1, 0);
    chk("rd_a1", dout, 8'hA1);
    op("r1_b", 0, 0, 0, 1, 1, 0);
    chk("rd_a2", dout, 8'hA2);
    chk("rd_rvch", rvch, 2'd1);

    // fill ch2 and overflow
    for (int i = 0; i < 5; i++) op("fill2", 1, 2, 'h20 + i, 0, 0, 0);
    chk("ovf2", ovf[2], 1'b1);
    chk("lvl2", level[2*LW +: LW], 3'd4);

    // empty ch0 read+write same cycle
    op("e0_rw", 1, 0, 'h55, 1, 0, 0);
    chk("udf0", udf[0], 1'b1);
    chk("lvl0", level[0 +: LW], 3'd1);

    // full ch3 read+write same cycle, then clear errors
    for (int i = 0; i < 4; i++) op("fill3", 1, 3, 'h30 + i, 0, 0, 0);
    op("f3_rw", 1, 3, 'hEE, 1, 3, 0);
    chk("lvl3", level[3*LW +: LW], 3'd3);
    chk("ovf3", ovf[3], 1'b1);
    op("clr", 0, 0, 0, 0, 0, 1);
    op("clr_set", 1, 2, 'h77, 1, 1, 1);

    // drain directed state, then random interleave
    for (int i = 0; i < 64; i++)
      op("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, NCH-1), $urandom_range(0, 255),
         $urandom_range(0, 1), $urandom_range(0, NCH-1), $urandom_range(0, 15) == 0);

    // asynchronous reset mid-burst
    @(negedge clk);
    we = 1; wch = 1; din = 8'h99; re = 1; rch = 2;
    #2 rstn = 0;
    #1 model_reset();
    check_all("mid_rst");
    we = 0; re = 0;
    @(negedge clk); rstn = 1;

    for (int i = 0; i < 32; i++)
      op("rnd2", $urandom_range(0, 1), $urandom_range(0, NCH-1), $urandom_range(0, 255),
         $urandom_range(0, 1), $urandom_range(0, NCH-1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
